// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle ripple-borrow subtractor, diff = A - B - bIn.
// Processes CHUNK bits per clock. The borrow is carried between chunks in a register.
//
// Ports:
//   clk, rstN          clock (rising edge), async active-low reset
//   A, B, bIn          minuend, subtrahend, borrow in
//   inValid/inReady    operand handshake (accepted only in IDLE)
//   diff               {borrow out, WIDTH-bit result}
//   outValid/outReady  result handshake (presented in DONE)
module chunked_subtractor #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bIn,
   input  logic             inValid,
   output logic             inReady,
   output logic [WIDTH:0]   diff,
   output logic             outValid,
   input  logic             outReady
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow;
   logic [IW-1:0]    idx;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK:0]   sub;
   logic             last;
   logic             accept;

   // One chunk of the ripple: the extra MSB of sub is the chunk borrow-out
   assign a_ch = a_q[idx*CHUNK +: CHUNK];
   assign b_ch = b_q[idx*CHUNK +: CHUNK];
   assign sub  = {1'b0, a_ch} - {1'b0, b_ch} - {{CHUNK{1'b0}}, borrow};
   assign last = (idx == IW'(N - 1));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d  = state;
      inReady  = 1'b0;
      outValid = 1'b0;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            inReady = 1'b1;
            if (inValid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            outValid = 1'b1;
            if (outReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operands are captured at accept so later input changes are harmless.
   // diff is only overwritten chunk by chunk while RUN is in progress.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         a_q    <= '0;
         b_q    <= '0;
         borrow <= 1'b0;
         idx    <= '0;
         diff   <= '0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         borrow <= bIn;
         idx    <= '0;
      end else if (state == RUN) begin
         diff[idx*CHUNK +: CHUNK] <= sub[CHUNK-1:0];
         borrow <= sub[CHUNK];
         idx    <= idx + IW'(1);
         if (last) begin
            diff[WIDTH] <= sub[CHUNK];
         end
      end
   end

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed and randomized checks of chunked_subtractor.
// Reference results come from plain 33-bit arithmetic on the operands.
module tb_chunked_subtractor;

   localparam int W = 32;
   localparam int N = 4;

   logic          clk;
   logic          rstN;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          bIn;
   logic          inValid;
   logic          inReady;
   logic [W:0]    diff;
   logic          outValid;
   logic          outReady;

   int checks = 0;
   int errors = 0;

   chunked_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
      .clk      (clk),
      .rstN     (rstN),
      .A        (A),
      .B        (B),
      .bIn      (bIn),
      .inValid  (inValid),
      .inReady  (inReady),
      .diff     (diff),
      .outValid (outValid),
      .outReady (outReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] golden(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bi);
      return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Issue one op, scramble the operand inputs after acceptance,
   // and wait (bounded) for the result. Leaves the unit in DONE.
   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic bi,
                         input logic [W:0] exp);
      int cnt;
      @(negedge clk);
      A = a; B = b; bIn = bi; inValid = 1'b1; outReady = 1'b0;
      check({tag, "_idle_rdy"}, 64'(inReady), 64'd1);
      @(negedge clk);
      inValid = 1'b0;
      A = $urandom; B = $urandom; bIn = 1'($urandom);
      check({tag, "_busy_rdy"}, 64'(inReady), 64'd0);
      cnt = 0;
      while (!outValid && cnt < 12) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, "_latency"}, 64'(cnt), 64'(N));
      check({tag, "_diff"}, 64'(diff), 64'(exp));
   endtask

   task automatic finish_op(input string tag);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      check({tag, "_hs_valid"}, 64'(outValid), 64'd0);
      check({tag, "_hs_rdy"}, 64'(inReady), 64'd1);
   endtask

   logic [W:0] q[$];
   logic [W:0] exp_v;
   int accepted;
   int delivered;
   int cyc;

   initial begin
      rstN = 1'b0; A = '0; B = '0; bIn = 1'b0;
      inValid = 1'b0; outReady = 1'b0;

      @(negedge clk);
      check("rst_rdy", 64'(inReady), 64'd1);
      check("rst_valid", 64'(outValid), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      rstN = 1'b1;

      run_op("t1", 32'd5, 32'd3, 1'b0, 33'h0_00000002);
      finish_op("t1");
      run_op("t2", 32'd0, 32'd1, 1'b0, 33'h1_FFFFFFFF);
      finish_op("t2");
      run_op("t3a", 32'h01000000, 32'd0, 1'b1, 33'h0_00FFFFFF);
      finish_op("t3a");
      run_op("t3b", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
      finish_op("t3b");

      // Backpressure with an ignored operand pulse
      run_op("t4", 32'd10, 32'd4, 1'b0, 33'h0_00000006);
      for (int i = 0; i < 6; i++) begin
         A = 32'd99; B = 32'd0; bIn = 1'b0;
         inValid = 1'(i % 2);
         @(negedge clk);
         check("t4_hold_valid", 64'(outValid), 64'd1);
         check("t4_hold_diff", 64'(diff), 64'h0_00000006);
         check("t4_hold_rdy", 64'(inReady), 64'd0);
      end
      inValid = 1'b0;
      finish_op("t4");
      @(negedge clk);
      check("t4_no_op_valid", 64'(outValid), 64'd0);
      check("t4_no_op_rdy", 64'(inReady), 64'd1);

      // Reset after the second RUN edge
      @(negedge clk);
      A = 32'h12345678; B = 32'd1; bIn = 1'b0; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      check("t5_rst_valid", 64'(outValid), 64'd0);
      check("t5_rst_rdy", 64'(inReady), 64'd1);
      check("t5_rst_diff", 64'(diff), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      run_op("t5", 32'd7, 32'd7, 1'b0, 33'h0_00000000);
      finish_op("t5");

      // Random back-to-back traffic against the queue model
      accepted = 0;
      delivered = 0;
      cyc = 0;
      while (delivered < 1000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         inValid  = (accepted < 1000) && ($urandom % 4 != 0);
         A        = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
         B        = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
         bIn      = 1'($urandom);
         outReady = 1'($urandom);
         #1;
         if (outValid) begin
            check("rnd_excl", 64'(inReady), 64'd0);
         end
         if (inValid && inReady) begin
            q.push_back(golden(A, B, bIn));
            accepted++;
         end
         if (outValid && outReady) begin
            if (q.size() == 0) begin
               check("rnd_spurious", 64'd1, 64'd0);
            end else begin
               exp_v = q.pop_front();
               check("rnd_diff", 64'(diff), 64'(exp_v));
            end
            delivered++;
         end
      end
      inValid = 1'b0;
      outReady = 1'b0;
      check("rnd_delivered", 64'(delivered), 64'd1000);
      check("rnd_balance", 64'(accepted), 64'(delivered));
      check("rnd_queue", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
